// File: rtl/sqrt_operand_norm.sv
// -----------------------------------------------------------------------------
// sqrt_operand_norm
//
// Normalizes an unsigned operand for a CORDIC square-root stage. The operand is
// shifted left two bits at a time until at least one of its top two bits is
// set. Shifting by an even amount keeps the square root exact up to a
// power-of-two scale: sqrt(x * 4^k) = sqrt(x) * 2^k. The downstream result is
// therefore right-shifted by out_shift (k) to undo the normalization.
//
// One operand is processed at a time: IDLE accepts, NORM shifts (one 2-bit
// step per cycle), DONE presents the result until the output handshake.
//
// Parameters
//   DSIZE      operand width (even, >= 4)
//   SSIZE      shift-count width (2**SSIZE > DSIZE/2)
//
// Ports
//   clock      single clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   upstream operand valid
//   in_ready   block can accept an operand (IDLE only, low during reset)
//   in_data    unsigned operand
//   out_valid  normalized result available (DONE)
//   out_ready  downstream accepts the result
//   out_data   normalized operand x * 4^k
//   out_shift  k, number of 2-bit left shifts applied
//   out_zero   operand was zero
// -----------------------------------------------------------------------------
module sqrt_operand_norm #(
    parameter int DSIZE = 16,
    parameter int SSIZE = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DSIZE-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] out_data,
    output logic [SSIZE-1:0] out_shift,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    // Working copy of the operand while it is being normalized, and the
    // number of 2-bit shifts applied so far.
    logic [DSIZE-1:0] data;
    logic [SSIZE-1:0] count;

    logic             accept;
    logic             in_is_zero;
    logic             top_set;

    // in_ready is gated by rst_n so an operand offered during reset is never
    // treated as accepted by the upstream stage.
    assign in_ready   = rst_n && (state == IDLE);
    assign out_valid  = (state == DONE);
    assign accept     = in_valid && in_ready;
    assign in_is_zero = (in_data == '0);
    assign top_set    = |data[DSIZE-1:DSIZE-2];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of the order the blocks are evaluated.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next-state gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = in_is_zero ? DONE : NORM;
                end
            end
            NORM: begin
                // A nonzero operand reaches a set top pair within DSIZE/2-1
                // shifts, so the count cannot wrap.
                if (top_set) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath. Result registers load only on entry to DONE, so they hold
    // steady through backpressure and keep the last result while IDLE.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            data      <= '0;
            count     <= '0;
            out_data  <= '0;
            out_shift <= '0;
            out_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        data  <= in_data;
                        count <= '0;
                        if (in_is_zero) begin
                            out_data  <= '0;
                            out_shift <= '0;
                            out_zero  <= 1'b1;
                        end
                    end
                end
                NORM: begin
                    if (top_set) begin
                        out_data  <= data;
                        out_shift <= count;
                        out_zero  <= 1'b0;
                    end else begin
                        data  <= {data[DSIZE-3:0], 2'b00};
                        count <= count + SSIZE'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sqrt_operand_norm.md
SQRT_OPERAND_NORM -- requirements
Module: sqrt_operand_norm

Interface
REQ-001 Parameter DSIZE, default 16, operand width; even, >=4.
REQ-002 Parameter SSIZE, default 4, shift-count width; 2**SSIZE > DSIZE/2.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 in_valid  input  1  upstream operand valid.
REQ-006 in_ready  output  1  block can accept an operand.
REQ-007 in_data  input  DSIZE  unsigned operand, full-scale integer.
REQ-008 out_valid  output  1  normalized operand available.
REQ-009 out_ready  input  1  downstream square-root stage accepts result.
REQ-010 out_data  output  DSIZE  normalized operand x*4^k; top two bits not both zero unless zero result.
REQ-011 out_shift  output  SSIZE  k, the number of 2-bit left shifts applied; downstream result is right-shifted by k.
REQ-012 out_zero  output  1  operand was zero.

Function
REQ-013 FSM states IDLE, NORM, DONE; only IDLE asserts in_ready, which is decoded from state and forced 0 while rst_n is low.
REQ-014 IDLE: on in_valid&&in_ready, in_data is captured, the count is cleared, and the FSM moves to NORM; if in_data==0, the FSM instead moves to DONE with out_zero=1, out_data=0, out_shift=0.
REQ-015 NORM, each cycle: if data[DSIZE-1:DSIZE-2]!=0, the FSM moves to DONE; otherwise data<<=2 (zero fill) and count+=1 in the same cycle.
REQ-016 The count never exceeds DSIZE/2-1 for nonzero input; no wrap-around is permitted.
REQ-017 Latency: accept at cycle N -> out_valid high in cycle N+2+k for nonzero input, and N+1 for zero input.
REQ-018 DONE: out_valid=1; out_data, out_shift, and out_zero hold stable until out_valid&&out_ready.
REQ-019 On the output handshake, the FSM returns to IDLE the next cycle; out_valid then drops to 0 and in_ready rises to 1.
REQ-020 in_valid is ignored outside IDLE; no operand is buffered; throughput is one operand per k+3 cycles (2 for zero input).
REQ-021 out_data, out_shift, and out_zero are registered outputs; they keep the last result in IDLE and are only meaningful while out_valid=1.
REQ-022 For nonzero input, out_data lies in [2^(DSIZE-2), 2^DSIZE-1], which is the range required by the downstream CORDIC square-root stage.

Reset
REQ-023 While rst_n=0 at an edge: state=IDLE, out_valid=0, out_data=0, out_shift=0, out_zero=0, and the internal count=0.
REQ-024 Reset asserted in NORM or DONE aborts the operation; no out_valid pulse is produced for the aborted operand.
REQ-025 After rst_n rises, in_ready=1 in the first cycle.

Verification (DSIZE=16)
REQ-026 Accept in_data=0x8000 at cycle N -> out_valid at N+2 with out_data=0x8000, out_shift=0, out_zero=0.
REQ-027 Accept in_data=0x0001 -> out_valid at N+9 with out_data=0x4000, out_shift=7.
REQ-028 Accept in_data=0x0300 -> out_valid at N+5 with out_data=0xC000, out_shift=3.
REQ-029 Accept in_data=0x0000 -> out_valid at N+1 with out_data=0x0000, out_shift=0, out_zero=1.
REQ-030 Backpressure: hold out_ready=0 for 5 cycles while in DONE -> outputs remain stable, in_ready=0, and in_valid pulses are ignored; raise out_ready -> IDLE and in_ready=1 next cycle.
REQ-031 Reset mid-NORM: accept 0x0001 and drive rst_n=0 at N+4 -> next cycle out_valid=0 and the FSM is in IDLE; no result is ever emitted for that operand.
